// File: rtl/ar_arbiter_if.sv
// AR-channel bundle between the two masters, the arbiter and the three slaves.
interface ar_arbiter_if;
    // master side
    logic [3:0]  M0_ARID;
    logic [31:0] M0_ARADDR;
    logic [3:0]  M0_ARLEN;
    logic [2:0]  M0_ARSIZE;
    logic [1:0]  M0_ARBURST;
    logic        M0_ARVALID;
    logic        M0_ARREADY;
    logic [3:0]  M1_ARID;
    logic [31:0] M1_ARADDR;
    logic [3:0]  M1_ARLEN;
    logic [2:0]  M1_ARSIZE;
    logic [1:0]  M1_ARBURST;
    logic        M1_ARVALID;
    logic        M1_ARREADY;
    // slave side
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        S1_ARVALID;
    logic        S2_ARVALID;
    logic        SD_ARVALID;
    logic        S1_ARREADY;
    logic        S2_ARREADY;
    logic        SD_ARREADY;
    logic [2:0]  r_done;
    logic        busy;

    // Environment view: masters, slaves and R-channel completion.
    modport master (
        output M0_ARID, M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST, M0_ARVALID,
        input  M0_ARREADY,
        output M1_ARID, M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST, M1_ARVALID,
        input  M1_ARREADY,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        input  S1_ARVALID, S2_ARVALID, SD_ARVALID,
        output S1_ARREADY, S2_ARREADY, SD_ARREADY,
        output r_done,
        input  busy
    );

    // Arbiter view.
    modport slave (
        input  M0_ARID, M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST, M0_ARVALID,
        output M0_ARREADY,
        input  M1_ARID, M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST, M1_ARVALID,
        output M1_ARREADY,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        output S1_ARVALID, S2_ARVALID, SD_ARVALID,
        input  S1_ARREADY, S2_ARREADY, SD_ARREADY,
        input  r_done,
        output busy
    );
endinterface

// File: rtl/ar_arbiter.sv
// Read-address arbiter: round-robin M0/M1, decode to S1/S2/default, and hold
// off the next grant until the addressed slave signals the end of the burst.
module ar_arbiter #(
    parameter logic [31:0] S1_BASE = 32'h0000_0000,
    parameter logic [31:0] S2_BASE = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         rstn,
    ar_arbiter_if.slave  bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;

    localparam logic [TAG_W-1:0] TAG_M0 = TAG_W'(4'b0001);
    localparam logic [TAG_W-1:0] TAG_M1 = TAG_W'(4'b0010);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_S1 = 2'd0,
        SEL_S2 = 2'd1,
        SEL_SD = 2'd2
    } sel_e;

    typedef struct packed {
        logic [TAG_W+ID_W-1:0] id;
        logic [ADDR_W-1:0]     addr;
        logic [LEN_W-1:0]      len;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
    } ar_pld_t;

    state_e  state_q, state_d;
    sel_e    sel_q, sel_d;
    logic    prio_q, prio_d;
    ar_pld_t pld_q, pld_d;

    logic    grant_m1;
    logic    m0_rdy, m1_rdy;
    logic    s1_vld, s2_vld, sd_vld;
    logic    sel_ready;
    logic    sel_done;

    // Map a master address onto its 64 KiB slave region.
    function automatic sel_e decode(input logic [ADDR_W-1:0] addr);
        if (addr[31:16] == S1_BASE[31:16]) begin
            return SEL_S1;
        end else if (addr[31:16] == S2_BASE[31:16]) begin
            return SEL_S2;
        end else begin
            return SEL_SD;
        end
    endfunction

    // Pick out the ready and burst-end signals of the latched target slave.
    always_comb begin
        sel_ready = 1'b0;
        sel_done  = 1'b0;
        case (sel_q)
            SEL_S1: begin
                sel_ready = bus.S1_ARREADY;
                sel_done  = bus.r_done[0];
            end
            SEL_S2: begin
                sel_ready = bus.S2_ARREADY;
                sel_done  = bus.r_done[1];
            end
            SEL_SD: begin
                sel_ready = bus.SD_ARREADY;
                sel_done  = bus.r_done[2];
            end
            default: begin
                sel_ready = 1'b0;
                sel_done  = 1'b0;
            end
        endcase
    end

    // Next-state, grant and capture logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        prio_d   = prio_q;
        pld_d    = pld_q;
        grant_m1 = 1'b0;
        m0_rdy   = 1'b0;
        m1_rdy   = 1'b0;
        s1_vld   = 1'b0;
        s2_vld   = 1'b0;
        sd_vld   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.M0_ARVALID || bus.M1_ARVALID) begin
                    // M1 wins when alone, or when both request and prio points at it.
                    grant_m1 = bus.M1_ARVALID && (!bus.M0_ARVALID || prio_q);
                    m0_rdy   = !grant_m1;
                    m1_rdy   = grant_m1;
                    prio_d   = !grant_m1;
                    state_d  = ST_ADDR;
                    if (grant_m1) begin
                        pld_d.id    = {TAG_M1, bus.M1_ARID};
                        pld_d.addr  = bus.M1_ARADDR;
                        pld_d.len   = bus.M1_ARLEN;
                        pld_d.size  = bus.M1_ARSIZE;
                        pld_d.burst = bus.M1_ARBURST;
                        sel_d       = decode(bus.M1_ARADDR);
                    end else begin
                        pld_d.id    = {TAG_M0, bus.M0_ARID};
                        pld_d.addr  = bus.M0_ARADDR;
                        pld_d.len   = bus.M0_ARLEN;
                        pld_d.size  = bus.M0_ARSIZE;
                        pld_d.burst = bus.M0_ARBURST;
                        sel_d       = decode(bus.M0_ARADDR);
                    end
                end
            end

            ST_ADDR: begin
                s1_vld = (sel_q == SEL_S1);
                s2_vld = (sel_q == SEL_S2);
                sd_vld = (sel_q == SEL_SD);
                if (sel_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // Burst-end pulses from non-selected slaves are ignored.
                if (sel_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, target and payload registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_S1;
            prio_q  <= 1'b0;
            pld_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            pld_q   <= pld_d;
        end
    end

    // Master accepts are combinational and forced low while reset is held.
    assign bus.M0_ARREADY = m0_rdy && rstn;
    assign bus.M1_ARREADY = m1_rdy && rstn;

    assign bus.S1_ARVALID = s1_vld;
    assign bus.S2_ARVALID = s2_vld;
    assign bus.SD_ARVALID = sd_vld;

    assign bus.ARID_S     = pld_q.id;
    assign bus.ARADDR_S   = pld_q.addr;
    assign bus.ARLEN_S    = pld_q.len;
    assign bus.ARSIZE_S   = pld_q.size;
    assign bus.ARBURST_S  = pld_q.burst;

    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ar_arbiter.sv
// Bench for ar_arbiter: transaction-level model plus directed scenarios.
module tb_ar_arbiter;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    ar_arbiter_if bus();

    ar_arbiter #(
        .S1_BASE(32'h0000_0000),
        .S2_BASE(32'h0001_0000)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: at most one read in flight.
    bit          mo_out;       // a read has been granted and not finished
    bit          mo_acc;       // its slave has taken the address
    int          mo_tgt;       // 0 = S1, 1 = S2, 2 = default
    int          mo_next;      // master favoured when both request
    bit [7:0]    mo_id;
    bit [31:0]   mo_addr;
    bit [3:0]    mo_len;
    bit [2:0]    mo_size;
    bit [1:0]    mo_burst;
    int          grant_log[$];

    function automatic int region(input logic [31:0] a);
        logic [15:0] hi;
        hi = a[31:16];
        if (hi == 16'h0000) return 0;
        if (hi == 16'h0001) return 1;
        return 2;
    endfunction

    function automatic int winner();
        if (bus.M0_ARVALID && bus.M1_ARVALID) return mo_next;
        if (bus.M0_ARVALID) return 0;
        if (bus.M1_ARVALID) return 1;
        return -1;
    endfunction

    function automatic logic slave_ready(input int k);
        if (k == 0) return bus.S1_ARREADY;
        if (k == 1) return bus.S2_ARREADY;
        return bus.SD_ARREADY;
    endfunction

    function automatic logic slave_valid(input int k);
        if (k == 0) return bus.S1_ARVALID;
        if (k == 1) return bus.S2_ARVALID;
        return bus.SD_ARVALID;
    endfunction

    // Advance the model on each clock edge; reset drops everything.
    always @(posedge clk or negedge rstn) begin
        int w;
        if (!rstn) begin
            mo_out = 0; mo_acc = 0; mo_tgt = 0; mo_next = 0;
            mo_id = '0; mo_addr = '0; mo_len = '0; mo_size = '0; mo_burst = '0;
        end else if (!mo_out) begin
            w = winner();
            if (w == 0) begin
                mo_out = 1; mo_acc = 0; mo_next = 1;
                mo_id = {4'b0001, bus.M0_ARID}; mo_addr = bus.M0_ARADDR;
                mo_len = bus.M0_ARLEN; mo_size = bus.M0_ARSIZE; mo_burst = bus.M0_ARBURST;
                mo_tgt = region(bus.M0_ARADDR);
            end else if (w == 1) begin
                mo_out = 1; mo_acc = 0; mo_next = 0;
                mo_id = {4'b0010, bus.M1_ARID}; mo_addr = bus.M1_ARADDR;
                mo_len = bus.M1_ARLEN; mo_size = bus.M1_ARSIZE; mo_burst = bus.M1_ARBURST;
                mo_tgt = region(bus.M1_ARADDR);
            end
        end else if (!mo_acc) begin
            if (slave_ready(mo_tgt)) mo_acc = 1;
        end else if (bus.r_done[mo_tgt]) begin
            mo_out = 0; mo_acc = 0;
        end
    end

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        int w;
        w = (rstn === 1'b1 && !mo_out) ? winner() : -1;
        chk("m0_arready", 32'(bus.M0_ARREADY), 32'(w == 0));
        chk("m1_arready", 32'(bus.M1_ARREADY), 32'(w == 1));
        chk("s1_arvalid", 32'(bus.S1_ARVALID), 32'(mo_out && !mo_acc && mo_tgt == 0));
        chk("s2_arvalid", 32'(bus.S2_ARVALID), 32'(mo_out && !mo_acc && mo_tgt == 1));
        chk("sd_arvalid", 32'(bus.SD_ARVALID), 32'(mo_out && !mo_acc && mo_tgt == 2));
        chk("busy",       32'(bus.busy),       32'(mo_out));
        chk("arid_s",     32'(bus.ARID_S),     32'(mo_id));
        chk("araddr_s",   bus.ARADDR_S,        mo_addr);
        chk("arlen_s",    32'(bus.ARLEN_S),    32'(mo_len));
        chk("arsize_s",   32'(bus.ARSIZE_S),   32'(mo_size));
        chk("arburst_s",  32'(bus.ARBURST_S),  32'(mo_burst));
        if (bus.M0_ARREADY === 1'b1) grant_log.push_back(0);
        if (bus.M1_ARREADY === 1'b1) grant_log.push_back(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sready(input int k, input logic v);
        if (k == 0) bus.S1_ARREADY = v;
        else if (k == 1) bus.S2_ARREADY = v;
        else bus.SD_ARREADY = v;
    endtask

    // Wait (bounded) until the given slave valid is seen at a falling edge.
    task automatic wait_valid(input int k);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (slave_valid(k) === 1'b1);
        end
        chk("wait_slave_valid", 32'(seen), 32'd1);
    endtask

    // Accept the address next cycle, then end the burst lat cycles later.
    task automatic complete(input int k, input int lat);
        tick();
        set_sready(k, 1'b1);
        tick();
        set_sready(k, 1'b0);
        repeat (lat) tick();
        bus.r_done = 3'(1 << k);
        tick();
        bus.r_done = 3'b000;
    endtask

    task automatic set_m0(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        bus.M0_ARID = id; bus.M0_ARADDR = a; bus.M0_ARLEN = len;
        bus.M0_ARSIZE = 3'd2; bus.M0_ARBURST = 2'd1;
    endtask

    task automatic set_m1(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        bus.M1_ARID = id; bus.M1_ARADDR = a; bus.M1_ARLEN = len;
        bus.M1_ARSIZE = 3'd3; bus.M1_ARBURST = 2'd2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};

        rstn = 1'b1;
        bus.M0_ARID = '0; bus.M0_ARADDR = '0; bus.M0_ARLEN = '0;
        bus.M0_ARSIZE = '0; bus.M0_ARBURST = '0; bus.M0_ARVALID = 1'b0;
        bus.M1_ARID = '0; bus.M1_ARADDR = '0; bus.M1_ARLEN = '0;
        bus.M1_ARSIZE = '0; bus.M1_ARBURST = '0; bus.M1_ARVALID = 1'b0;
        bus.S1_ARREADY = 1'b0; bus.S2_ARREADY = 1'b0; bus.SD_ARREADY = 1'b0;
        bus.r_done = 3'b000;
        #1 rstn = 1'b0;
        repeat (3) tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_arid", 32'(bus.ARID_S), 32'd0);
        rstn = 1'b1;
        tick();

        // Single M0 read to S1.
        set_m0(4'h3, 32'h0000_0040, 4'd3);
        bus.M0_ARVALID = 1'b1;
        @(negedge clk);
        chk("t1_m0_ready_at_t", 32'(bus.M0_ARREADY), 32'd1);
        tick();
        bus.M0_ARVALID = 1'b0;
        wait_valid(0);
        chk("t1_arid_s", 32'(bus.ARID_S), 32'h13);
        chk("t1_m0_ready_off", 32'(bus.M0_ARREADY), 32'd0);
        complete(0, 6);
        @(negedge clk);
        chk("t1_busy_fall", 32'(bus.busy), 32'd0);
        tick();

        // Default decode from M1.
        set_m1(4'hA, 32'h2000_0000, 4'd0);
        bus.M1_ARVALID = 1'b1;
        @(negedge clk);
        chk("t2_m1_ready", 32'(bus.M1_ARREADY), 32'd1);
        tick();
        bus.M1_ARVALID = 1'b0;
        wait_valid(2);
        chk("t2_s1_quiet", 32'(bus.S1_ARVALID), 32'd0);
        chk("t2_s2_quiet", 32'(bus.S2_ARVALID), 32'd0);
        chk("t2_arid_s", 32'(bus.ARID_S), 32'h2A);
        complete(2, 1);
        tick();

        // Contention: both masters request continuously.
        grant_log.delete();
        set_m0(4'h1, 32'h0001_0010, 4'd1);
        set_m1(4'h5, 32'h0000_0100, 4'd2);
        bus.M0_ARVALID = 1'b1;
        bus.M1_ARVALID = 1'b1;
        wait_valid(1);
        chk("t3_arid_m0", 32'(bus.ARID_S), 32'h11);
        complete(1, 2);
        wait_valid(0);
        chk("t3_arid_m1", 32'(bus.ARID_S), 32'h25);
        complete(0, 2);
        wait_valid(1);
        complete(1, 0);
        wait_valid(0);
        complete(0, 0);
        bus.M0_ARVALID = 1'b0;
        bus.M1_ARVALID = 1'b0;
        chk("t3_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            chk("t3_grant_order", 32'(grant_log[i]), 32'(exp_g[i]));
        end
        tick();

        // Busy blocking: M0 waits while M1's burst is in DATA.
        set_m1(4'h7, 32'h0001_0000, 4'd1);
        bus.M1_ARVALID = 1'b1;
        @(negedge clk);
        chk("t4_m1_ready", 32'(bus.M1_ARREADY), 32'd1);
        tick();
        bus.M1_ARVALID = 1'b0;
        wait_valid(1);
        tick();
        bus.S2_ARREADY = 1'b1;
        tick();
        bus.S2_ARREADY = 1'b0;
        set_m0(4'h1, 32'h0000_0040, 4'd0);
        bus.M0_ARVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_m0_blocked", 32'(bus.M0_ARREADY), 32'd0);
            tick();
        end
        bus.r_done = 3'b101;
        @(negedge clk);
        chk("t4_busy_held", 32'(bus.busy), 32'd1);
        chk("t4_m0_blocked_wrong_done", 32'(bus.M0_ARREADY), 32'd0);
        tick();
        bus.r_done = 3'b010;
        @(negedge clk);
        chk("t4_m0_blocked_done_cycle", 32'(bus.M0_ARREADY), 32'd0);
        tick();
        bus.r_done = 3'b000;
        @(negedge clk);
        chk("t4_m0_granted", 32'(bus.M0_ARREADY), 32'd1);
        tick();
        bus.M0_ARVALID = 1'b0;
        wait_valid(0);
        complete(0, 1);
        tick();

        // Reset while the slave address is outstanding.
        set_m0(4'h9, 32'h0001_0020, 4'd2);
        bus.M0_ARVALID = 1'b1;
        tick();
        bus.M0_ARVALID = 1'b0;
        wait_valid(1);
        chk("t5_arid_before", 32'(bus.ARID_S), 32'h19);
        #2 rstn = 1'b0;
        #1;
        chk("t5_s2_async", 32'(bus.S2_ARVALID), 32'd0);
        chk("t5_busy_async", 32'(bus.busy), 32'd0);
        chk("t5_arid_async", 32'(bus.ARID_S), 32'd0);
        chk("t5_addr_async", bus.ARADDR_S, 32'd0);
        chk("t5_len_async", 32'(bus.ARLEN_S), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        set_m0(4'h1, 32'h0000_0040, 4'd0);
        set_m1(4'h2, 32'h0001_0000, 4'd0);
        bus.M0_ARVALID = 1'b1;
        bus.M1_ARVALID = 1'b1;
        @(negedge clk);
        chk("t5_prio_reset_m0", 32'(bus.M0_ARREADY), 32'd1);
        chk("t5_prio_reset_m1", 32'(bus.M1_ARREADY), 32'd0);
        tick();
        bus.M0_ARVALID = 1'b0;
        bus.M1_ARVALID = 1'b0;
        wait_valid(0);
        complete(0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ar_arbiter.md
# ar_arbiter

Read-address (AR) channel arbiter and sequencer for the two-master/three-slave AXI interconnect. It round-robins between M0 and M1 for the single shared read path, decodes ARADDR to S1, S2 or the default slave, and forwards one registered AR transaction. It then holds off further grants until the addressed slave finishes the burst (RLAST handshake). This serialises reads so the R-channel return mux never sees interleaved bursts.

## Interface
Parameters:
- `S1_BASE`, default 32'h0000_0000: S1 region base (64 KiB, match on ARADDR[31:16]).
- `S2_BASE`, default 32'h0001_0000: S2 region base (64 KiB, match on ARADDR[31:16]).

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `M0_ARID` / `M1_ARID` in 4: master IDs.
- `M0_ARADDR` / `M1_ARADDR` in 32: addresses.
- `M0_ARLEN` / `M1_ARLEN` in 4: burst length minus 1.
- `M0_ARSIZE` / `M1_ARSIZE` in 3, `M0_ARBURST` / `M1_ARBURST` in 2: forwarded unchanged.
- `M0_ARVALID` / `M1_ARVALID` in 1: master requests.
- `M0_ARREADY` / `M1_ARREADY` out 1: master accept.
- `ARID_S` out 8: {master tag, master ID}; tag 4'b0001 = M0, 4'b0010 = M1.
- `ARADDR_S` out 32, `ARLEN_S` out 4, `ARSIZE_S` out 3, `ARBURST_S` out 2: registered payload, shared by all slaves.
- `S1_ARVALID`, `S2_ARVALID`, `SD_ARVALID` out 1: one-hot slave valid.
- `S1_ARREADY`, `S2_ARREADY`, `SD_ARREADY` in 1: slave accept.
- `r_done` in 3: {SD, S2, S1}; a bit is high for one cycle when RVALID&RREADY&RLAST completes on that slave.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: grant and capture.
  - ADDR: slave AR handshake.
  - DATA: wait for burst end.
- IDLE:
  - If no ARVALID is high, stay in IDLE.
  - If exactly one ARVALID is high, grant that master.
  - If both are high, grant the master indicated by priority pointer `prio` (0 = M0, 1 = M1).
  - The granted ARREADY is driven combinationally high in that same cycle.
  - At the clock edge: capture the payload, set ARID_S = {tag, ARID}, latch the decoded target `sel`, flip `prio` to the non-granted master, and go to ADDR.
- Decode:
  - ARADDR[31:16] == S1_BASE[31:16] selects S1.
  - ARADDR[31:16] == S2_BASE[31:16] selects S2.
  - Any other address selects SD.
  - Decode is done on the master address at grant time.
- ADDR:
  - Drive `<sel>_ARVALID` = 1; the other slave valids are 0.
  - Payload is held stable.
  - When `<sel>_ARREADY` = 1, go to DATA at the next edge.
- DATA:
  - All slave valids and master ARREADYs are 0.
  - When `r_done[sel]` = 1, go to IDLE. `r_done` bits for non-selected slaves are ignored.
- `prio` changes only on a grant. A lone requester still flips it.
- Master ARREADY is never high outside IDLE. At most one master ARREADY is high in any cycle.

## Timing
- Reset values:
  - State IDLE, `prio` = 0, `sel` = 0.
  - All ARVALID/ARREADY outputs 0, `busy` = 0.
  - ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S all 0.
- Grant latency: master ARVALID sampled in IDLE at cycle t gives ARREADY in cycle t and slave ARVALID from cycle t+1.
- A slave ARREADY that is already high in cycle t+1 completes the handshake in t+1; DATA starts at t+2.
- `r_done[sel]` in cycle j gives IDLE at j+1. The earliest next grant is in cycle j+1.
- `r_done[sel]` arriving in ADDR (illegal) is ignored.
- Both masters requesting in every IDLE cycle get strictly alternating grants.
- A master deasserting ARVALID before its grant is not remembered.
- Asserting reset mid-ADDR or mid-DATA returns everything to reset values immediately (asynchronous). The outstanding transaction is dropped.

## Test plan
- Reset mid-ADDR:
  - Stimulus: M0 grant to S2, then assert rstn = 0 while S2_ARVALID is high.
  - Response: all outputs go to 0 asynchronously; after release, state is IDLE with `prio` = 0.
- Single M0 read to S1:
  - Stimulus: M0_ARVALID with ARADDR = 0x0000_0040, ARID = 4'h3, ARLEN = 3; S1_ARREADY is high one cycle after S1_ARVALID rises; `r_done[0]` pulses 6 cycles later.
  - Response:
    - M0_ARREADY is high 1 cycle at t.
    - S1_ARVALID is high from t+1 until handshake; ARID_S = 8'h13.
    - `busy` falls the cycle after `r_done[0]`.
- Contention:
  - Stimulus: both masters hold ARVALID continuously; each burst is closed by `r_done`.
  - Response: grants go M0, M1, M0, M1; M1 ARID_S tag is 4'b0010.
- Default decode:
  - Stimulus: M1 reads ARADDR = 0x2000_0000.
  - Response: only SD_ARVALID rises; S1_ARVALID and S2_ARVALID stay 0.
- Busy blocking:
  - Stimulus: M0 asserts ARVALID while M1's burst is in DATA.
  - Response: M0_ARREADY stays 0 until the cycle after `r_done[sel]`, then is granted.
  - A pulse on a non-selected `r_done` bit has no effect.
